// File: rtl/apb_master_arb.sv
// Round-robin arbiter that shares one APB4 master port between NREQ requesters.
// Optional ACCESS-phase timeout abort is enabled by defining APB_MASTER_ARB_TIMEOUT_EN.
module apb_master_arb #(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*16-1:0]   req_addr,
  input  logic [NREQ*32-1:0]   req_wdata,
  input  logic [NREQ*4-1:0]    req_strb,
  input  logic [NREQ*3-1:0]    req_prot,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [15:0]          paddr,
  output logic [2:0]           pprot,
  output logic [31:0]          pwdata,
  output logic [3:0]           pwstrb,
  input  logic                 pready,
  input  logic [31:0]          prdata,
  input  logic                 pslverr,
  output logic                 pwakeup
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e          state_q,      state_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic [IW-1:0]   owner_q,      owner_d;
  logic            psel_q,       psel_d;
  logic            penable_q,    penable_d;
  logic            pwrite_q,     pwrite_d;
  logic [15:0]     paddr_q,      paddr_d;
  logic [2:0]      pprot_q,      pprot_d;
  logic [31:0]     pwdata_q,     pwdata_d;
  logic [3:0]      pwstrb_q,     pwstrb_d;
  logic [NREQ-1:0] rsp_valid_q,  rsp_valid_d;
  logic [31:0]     rsp_rdata_q,  rsp_rdata_d;
  logic            rsp_err_q,    rsp_err_d;
  logic            pwakeup_q,    pwakeup_d;
`ifdef APB_MASTER_ARB_TIMEOUT_EN
  logic [7:0]      wait_cnt_q,   wait_cnt_d;
`endif

  logic [IW-1:0]   winner_s;
  logic            found_s;
  logic [NREQ-1:0] req_ready_s;

  // Requester index 'off' positions after the one just past base, wrapping at NREQ.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
    int t;
    t = int'(base) + 1 + off;
    if (t >= NREQ) begin
      t = t - NREQ;
    end else begin
      t = t;
    end
    return IW'(t);
  endfunction

  // Circular search for the first valid requester after the last grant.
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_s && req_valid[rr_idx(last_grant_q, i)]) begin
        winner_s = rr_idx(last_grant_q, i);
        found_s  = 1'b1;
      end else begin
        winner_s = winner_s;
      end
    end
  end

  // Combinational accept strobe; only offered in IDLE and never during reset.
  always_comb begin
    req_ready_s = '0;
    if ((state_q == ST_IDLE) && found_s && !preset) begin
      req_ready_s[winner_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pprot_d      = pprot_q;
    pwdata_d     = pwdata_q;
    pwstrb_d     = pwstrb_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    pwakeup_d    = (|req_valid) || (state_q != ST_IDLE);
`ifdef APB_MASTER_ARB_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d      = ST_SETUP;
          last_grant_d = winner_s;
          owner_d      = winner_s;
          psel_d       = 1'b1;
          penable_d    = 1'b0;
          pwrite_d     = req_write[winner_s];
          paddr_d      = req_addr[winner_s*16 +: 16];
          pprot_d      = req_prot[winner_s*3 +: 3];
          // Reads never expose stale write data or strobes on the bus.
          pwdata_d     = req_write[winner_s] ? req_wdata[winner_s*32 +: 32] : 32'h0000_0000;
          pwstrb_d     = req_write[winner_s] ? req_strb[winner_s*4 +: 4] : 4'h0;
        end else begin
          psel_d       = 1'b0;
          penable_d    = 1'b0;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
`ifdef APB_MASTER_ARB_TIMEOUT_EN
        wait_cnt_d = 8'd0;
`endif
      end
      ST_ACCESS: begin
        if (pready) begin
          state_d              = ST_IDLE;
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = pwrite_q ? 32'h0000_0000 : prdata;
          rsp_err_d            = pslverr;
        end else begin
`ifdef APB_MASTER_ARB_TIMEOUT_EN
          // Abort on the edge where the wait count would reach TIMEOUT_CYCLES.
          if (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
            state_d              = ST_IDLE;
            psel_d               = 1'b0;
            penable_d            = 1'b0;
            rsp_valid_d[owner_q] = 1'b1;
            rsp_rdata_d          = 32'h0000_0000;
            rsp_err_d            = 1'b1;
          end else begin
            wait_cnt_d           = wait_cnt_q + 8'd1;
          end
`else
          state_d = ST_ACCESS;
`endif
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IW'(NREQ - 1);
      owner_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= 16'h0000;
      pprot_q      <= 3'b000;
      pwdata_q     <= 32'h0000_0000;
      pwstrb_q     <= 4'h0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= 32'h0000_0000;
      rsp_err_q    <= 1'b0;
      pwakeup_q    <= 1'b0;
`ifdef APB_MASTER_ARB_TIMEOUT_EN
      wait_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pprot_q      <= pprot_d;
      pwdata_q     <= pwdata_d;
      pwstrb_q     <= pwstrb_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      pwakeup_q    <= pwakeup_d;
`ifdef APB_MASTER_ARB_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pprot     = pprot_q;
  assign pwdata    = pwdata_q;
  assign pwstrb    = pwstrb_q;
  assign pwakeup   = pwakeup_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed self-checking bench for apb_master_arb (NREQ=2, TIMEOUT_CYCLES=4).
module tb_apb_master_arb;

  logic        pclk = 1'b0;
  logic        preset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_strb;
  logic [5:0]  req_prot;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [2:0]  pprot;
  logic [31:0] pwdata;
  logic [3:0]  pwstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        pwakeup;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_master_arb #(.NREQ(2), .TIMEOUT_CYCLES(4)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pprot(pprot),
    .pwdata(pwdata), .pwstrb(pwstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr), .pwakeup(pwakeup)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge pclk);
  endtask

  logic [1:0]  exp_g [4];
  logic [15:0] exp_a [4];
  int served0, served1;

  initial begin
    preset = 1'b1; req_valid = 2'b00; req_write = 2'b00; req_addr = 32'h0;
    req_wdata = 64'h0; req_strb = 8'h0; req_prot = 6'h0;
    pready = 1'b0; prdata = 32'h0; pslverr = 1'b0;

    // Reset state
    wait_cyc(2);
    chk("rst_psel", {31'd0, psel}, 32'd0);
    chk("rst_penable", {31'd0, penable}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_pwakeup", {31'd0, pwakeup}, 32'd0);
    chk("rst_paddr", {16'd0, paddr}, 32'd0);
    req_valid = 2'b01; #1;
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);

    // Single write from req0, pready immediate
    @(negedge pclk);
    preset = 1'b0; req_write = 2'b01; req_addr = {16'h0000, 16'h0010};
    req_wdata = {32'h0, 32'hDEAD_BEEF}; req_strb = 8'h0F; req_prot = 6'b000_010;
    pready = 1'b1; #1;
    chk("wr_req_ready", {30'd0, req_ready}, 32'd1);
    wait_cyc(1);
    req_valid = 2'b00;
    chk("wr_setup_psel", {31'd0, psel}, 32'd1);
    chk("wr_setup_penable", {31'd0, penable}, 32'd0);
    chk("wr_paddr", {16'd0, paddr}, 32'h0010);
    chk("wr_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("wr_pwstrb", {28'd0, pwstrb}, 32'hF);
    chk("wr_pwrite", {31'd0, pwrite}, 32'd1);
    chk("wr_pprot", {29'd0, pprot}, 32'd2);
    chk("wr_pwakeup", {31'd0, pwakeup}, 32'd1);
    wait_cyc(1);
    chk("wr_access_penable", {31'd0, penable}, 32'd1);
    chk("wr_access_rsp", {30'd0, rsp_valid}, 32'd0);
    wait_cyc(1);
    chk("wr_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("wr_rsp_rdata", rsp_rdata, 32'd0);
    chk("wr_idle_psel", {31'd0, psel}, 32'd0);

    // Read from req1 with two wait states
    pready = 1'b0; req_valid = 2'b10; req_write = 2'b00;
    req_addr = {16'h0024, 16'h0000}; req_wdata = {32'hFFFF_FFFF, 32'h0};
    req_strb = 8'hF0; #1;
    chk("rd_req_ready", {30'd0, req_ready}, 32'd2);
    wait_cyc(1);
    req_valid = 2'b00;
    chk("rd_pwstrb", {28'd0, pwstrb}, 32'd0);
    chk("rd_pwdata", pwdata, 32'd0);
    chk("rd_paddr", {16'd0, paddr}, 32'h0024);
    wait_cyc(2);
    chk("rd_wait_penable", {31'd0, penable}, 32'd1);
    chk("rd_wait_psel", {31'd0, psel}, 32'd1);
    wait_cyc(1);
    chk("rd_wait2_rsp", {30'd0, rsp_valid}, 32'd0);
    pready = 1'b1; prdata = 32'h1234_5678;
    wait_cyc(1);
    chk("rd_rsp_valid", {30'd0, rsp_valid}, 32'd2);
    chk("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);

    // Contention: both requesters held valid for four transfers
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    exp_a[0] = 16'h0100; exp_a[1] = 16'h0200; exp_a[2] = 16'h0100; exp_a[3] = 16'h0200;
    served0 = 0; served1 = 0;
    req_addr = {16'h0200, 16'h0100}; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_grant", {30'd0, req_ready}, {30'd0, exp_g[k]});
      wait_cyc(1);
      chk("cont_paddr", {16'd0, paddr}, {16'd0, exp_a[k]});
      wait_cyc(2);
      chk("cont_rsp", {30'd0, rsp_valid}, {30'd0, exp_g[k]});
      if (rsp_valid == 2'b01) served0++;
      else if (rsp_valid == 2'b10) served1++;
      if (k == 3) req_valid = 2'b00;
    end
    chk("cont_served0", served0, 32'd2);
    chk("cont_served1", served1, 32'd2);

    // Slave error then a clean transfer
    req_valid = 2'b01; pslverr = 1'b1; prdata = 32'h0BAD_0BAD; #1;
    chk("err_req_ready", {30'd0, req_ready}, 32'd1);
    wait_cyc(1);
    req_valid = 2'b00;
    wait_cyc(2);
    chk("err_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("err_rsp_err", {31'd0, rsp_err}, 32'd1);
    pslverr = 1'b0; req_valid = 2'b10; prdata = 32'h0000_C0DE; #1;
    chk("ok_req_ready", {30'd0, req_ready}, 32'd2);
    wait_cyc(1);
    req_valid = 2'b00;
    wait_cyc(2);
    chk("ok_rsp_valid", {30'd0, rsp_valid}, 32'd2);
    chk("ok_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("ok_rsp_rdata", rsp_rdata, 32'h0000_C0DE);

    // Reset during ACCESS with pready low
    pready = 1'b0; req_valid = 2'b10; #1;
    chk("rstm_req_ready", {30'd0, req_ready}, 32'd2);
    wait_cyc(1);
    req_valid = 2'b00;
    wait_cyc(1);
    chk("rstm_penable_pre", {31'd0, penable}, 32'd1);
    preset = 1'b1;
    wait_cyc(1);
    chk("rstm_psel", {31'd0, psel}, 32'd0);
    chk("rstm_penable", {31'd0, penable}, 32'd0);
    chk("rstm_rsp", {30'd0, rsp_valid}, 32'd0);
    preset = 1'b0;
    wait_cyc(1);
    chk("rstm_rsp_after", {30'd0, rsp_valid}, 32'd0);
    req_valid = 2'b11; pready = 1'b1; prdata = 32'hA5A5_0F0F; #1;
    chk("rstm_req0_wins", {30'd0, req_ready}, 32'd1);
    wait_cyc(1);
    req_valid = 2'b00;
    wait_cyc(2);
    chk("rstm_next_rsp", {30'd0, rsp_valid}, 32'd1);
    chk("rstm_next_rdata", rsp_rdata, 32'hA5A5_0F0F);

`ifdef APB_MASTER_ARB_TIMEOUT_EN
    // Timeout abort after four ACCESS cycles
    pready = 1'b0; prdata = 32'hFFFF_FFFF; req_valid = 2'b01; #1;
    chk("to_req_ready", {30'd0, req_ready}, 32'd1);
    wait_cyc(1);
    req_valid = 2'b00;
    wait_cyc(4);
    chk("to_last_access_psel", {31'd0, psel}, 32'd1);
    chk("to_last_access_penable", {31'd0, penable}, 32'd1);
    chk("to_last_access_rsp", {30'd0, rsp_valid}, 32'd0);
    wait_cyc(1);
    chk("to_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("to_rsp_rdata", rsp_rdata, 32'd0);
    chk("to_psel", {31'd0, psel}, 32'd0);
    chk("to_penable", {31'd0, penable}, 32'd0);
    req_valid = 2'b10; #1;
    chk("to_idle_ready", {30'd0, req_ready}, 32'd2);
    wait_cyc(1);
    req_valid = 2'b00;
`endif

    wait_cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
